// File: rtl/edge_pulse_pkg.sv
// Shared types for the edge pulse bank: per-channel debounce FSM states,
// edge-mode encoding and the counter-width helper.
package edge_pulse_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        CHECK_HI  = 2'd1,
        STABLE_HI = 2'd2,
        CHECK_LO  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'b00,
        MODE_RISE = 2'b01,
        MODE_FALL = 2'b10,
        MODE_BOTH = 2'b11
    } mode_t;

    // One spare bit above the value's own width so a counter can never wrap.
    function automatic int cnt_w(input int value);
        return $clog2((value < 2) ? 2 : value) + 1;
    endfunction

endpackage

// File: rtl/edge_pulse_chan.sv
// One channel: synchroniser, debounce FSM and retriggerable pulse stretcher.
// Mode only qualifies the accepted edge; it never touches debounce tracking.
module edge_pulse_chan
    import edge_pulse_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int PULSE_LEN    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       L,
    input  logic [1:0] mode,
    output logic       P,
    output logic       level
);

    localparam int DB_W = cnt_w(DEBOUNCE_CYC);
    localparam int PL_W = cnt_w(PULSE_LEN);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("edge_pulse_chan: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYC < 1) begin : g_bad_db
        $error("edge_pulse_chan: DEBOUNCE_CYC must be >= 1");
    end
    if (PULSE_LEN < 1) begin : g_bad_pl
        $error("edge_pulse_chan: PULSE_LEN must be >= 1");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [DB_W-1:0]        r_db_cnt;
    logic [DB_W-1:0]        w_db_cnt_nxt;
    logic [DB_W-1:0]        w_db_inc;
    logic [PL_W-1:0]        r_pulse_cnt;
    logic                   w_sync;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_fire;
    mode_t                  w_mode;

    assign w_sync   = r_sync[SYNC_STAGES-1];
    assign w_db_inc = r_db_cnt + DB_W'(1);
    assign w_mode   = mode_t'(mode);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], L};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= STABLE_LO;
            r_db_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_db_cnt <= w_db_cnt_nxt;
        end
    end

    // The edge whose increment would reach DEBOUNCE_CYC is the accepting edge,
    // so the new level wins after exactly DEBOUNCE_CYC synchronised samples.
    always_comb begin
        w_state_nxt  = r_state;
        w_db_cnt_nxt = r_db_cnt;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        case (r_state)
            STABLE_LO: begin
                if (w_sync) begin
                    if (DEBOUNCE_CYC == 1) begin
                        w_state_nxt = STABLE_HI;
                        w_rise      = 1'b1;
                    end else begin
                        w_state_nxt  = CHECK_HI;
                        w_db_cnt_nxt = DB_W'(1);
                    end
                end
            end
            CHECK_HI: begin
                if (!w_sync) begin
                    w_state_nxt  = STABLE_LO;
                    w_db_cnt_nxt = '0;
                end else if (w_db_inc == DB_W'(DEBOUNCE_CYC)) begin
                    w_state_nxt  = STABLE_HI;
                    w_db_cnt_nxt = '0;
                    w_rise       = 1'b1;
                end else begin
                    w_db_cnt_nxt = w_db_inc;
                end
            end
            STABLE_HI: begin
                if (!w_sync) begin
                    if (DEBOUNCE_CYC == 1) begin
                        w_state_nxt = STABLE_LO;
                        w_fall      = 1'b1;
                    end else begin
                        w_state_nxt  = CHECK_LO;
                        w_db_cnt_nxt = DB_W'(1);
                    end
                end
            end
            CHECK_LO: begin
                if (w_sync) begin
                    w_state_nxt  = STABLE_HI;
                    w_db_cnt_nxt = '0;
                end else if (w_db_inc == DB_W'(DEBOUNCE_CYC)) begin
                    w_state_nxt  = STABLE_LO;
                    w_db_cnt_nxt = '0;
                    w_fall       = 1'b1;
                end else begin
                    w_db_cnt_nxt = w_db_inc;
                end
            end
            default: begin
                w_state_nxt  = STABLE_LO;
                w_db_cnt_nxt = '0;
            end
        endcase
    end

    assign w_fire = (w_rise && (w_mode == MODE_RISE || w_mode == MODE_BOTH)) ||
                    (w_fall && (w_mode == MODE_FALL || w_mode == MODE_BOTH));

    // A new event reloads rather than accumulates, stretching an active pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pulse_cnt <= '0;
        end else if (w_fire) begin
            r_pulse_cnt <= PL_W'(PULSE_LEN);
        end else if (r_pulse_cnt != '0) begin
            r_pulse_cnt <= r_pulse_cnt - PL_W'(1);
        end
    end

    assign P     = (r_pulse_cnt != '0);
    assign level = (r_state == STABLE_HI) || (r_state == CHECK_LO);

endmodule

// File: rtl/edge_pulse_bank.sv
// Bank of independent debounced edge-to-pulse channels with a combined
// any-pulse flag.
module edge_pulse_bank
    import edge_pulse_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int PULSE_LEN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH-1:0]   L,
    input  logic [2*N_CH-1:0] mode,
    output logic [N_CH-1:0]   P,
    output logic [N_CH-1:0]   level,
    output logic              any_p
);

    if (N_CH < 1 || N_CH > 32) begin : g_bad_nch
        $error("edge_pulse_bank: N_CH must be in 1..32");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        edge_pulse_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE_CYC(DEBOUNCE_CYC),
            .PULSE_LEN   (PULSE_LEN)
        ) u_chan (
            .clk  (clk),
            .reset(reset),
            .L    (L[i]),
            .mode (mode[2*i+1:2*i]),
            .P    (P[i]),
            .level(level[i])
        );
    end

    assign any_p = |P;

endmodule

// File: tb/tb_edge_pulse_bank.sv
// Scoreboard bench: stimulus queues per-cycle expectations, a monitor on the
// falling edge pops and compares them against three differently sized banks.
module tb_edge_pulse_bank;
    import edge_pulse_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // A: defaults, 4 channels
    logic       rst_a;
    logic [3:0] L_a, P_a, lvl_a;
    logic [7:0] mode_a;
    logic       any_a;
    // B: SYNC_STAGES=3, DEBOUNCE_CYC=1, PULSE_LEN=5
    logic       rst_b;
    logic [0:0] L_b, P_b, lvl_b;
    logic [1:0] mode_b;
    logic       any_b;
    // C: defaults with PULSE_LEN=4
    logic       rst_c;
    logic [0:0] L_c, P_c, lvl_c;
    logic [1:0] mode_c;
    logic       any_c;

    edge_pulse_bank #(.N_CH(4)) u_a (
        .clk(clk), .reset(rst_a), .L(L_a), .mode(mode_a),
        .P(P_a), .level(lvl_a), .any_p(any_a)
    );

    edge_pulse_bank #(.N_CH(1), .SYNC_STAGES(3), .DEBOUNCE_CYC(1), .PULSE_LEN(5)) u_b (
        .clk(clk), .reset(rst_b), .L(L_b), .mode(mode_b),
        .P(P_b), .level(lvl_b), .any_p(any_b)
    );

    edge_pulse_bank #(.N_CH(1), .PULSE_LEN(4)) u_c (
        .clk(clk), .reset(rst_c), .L(L_c), .mode(mode_c),
        .P(P_c), .level(lvl_c), .any_p(any_c)
    );

    typedef struct {
        int         cyc;
        int         dut;
        logic [3:0] p;
        logic [3:0] lvl;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   stim_done = 1'b0;

    task automatic exp_range(input int d, input int c0, input int c1,
                             input logic [3:0] p, input logic [3:0] lv, input string nm);
        for (int c = c0; c <= c1; c++) begin
            exp_t e;
            int   idx;
            e.cyc = c; e.dut = d; e.p = p; e.lvl = lv; e.nm = nm;
            idx = sb.size();
            while (idx > 0 && sb[idx-1].cyc > c) idx--;
            sb.insert(idx, e);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: sole owner of the error/check counters.
    initial begin : monitor
        exp_t       e;
        logic [3:0] ap, al;
        logic       aa;
        int         drain = 0;
        bit         b_saw_check = 1'b0;
        forever begin
            @(negedge clk);
            if (u_b.g_chan[0].u_chan.r_state == CHECK_HI ||
                u_b.g_chan[0].u_chan.r_state == CHECK_LO)
                b_saw_check = 1'b1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                case (e.dut)
                    0:       begin ap = P_a;          al = lvl_a;          aa = any_a; end
                    1:       begin ap = {3'b0, P_b};  al = {3'b0, lvl_b};  aa = any_b; end
                    default: begin ap = {3'b0, P_c};  al = {3'b0, lvl_c};  aa = any_c; end
                endcase
                checks++;
                if (e.cyc != cyc || ap !== e.p || al !== e.lvl || aa !== (|e.p)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d(exp@%0d) dut=%0d: got P=%b level=%b any_p=%b, want P=%b level=%b any_p=%b",
                             e.nm, cyc, e.cyc, e.dut, ap, al, aa, e.p, e.lvl, |e.p);
                end
            end
            if (stim_done || cyc > 3000) begin
                if (sb.size() == 0 || drain >= 40 || cyc > 3000) begin
                    checks++;
                    if (sb.size() != 0 || !stim_done) begin
                        errors++;
                        $display("FAIL drain: got %0d pending expectations (stim_done=%0d), want 0",
                                 sb.size(), stim_done);
                    end
                    checks++;
                    if (b_saw_check) begin
                        errors++;
                        $display("FAIL b_no_check_state: got CHECK state visited, want never with DEBOUNCE_CYC=1");
                    end
                    $display("Result: errors=%0d of %0d checks", errors, checks);
                    $finish;
                end
                drain++;
            end
        end
    end

    initial begin : stimulus
        int k;
        int r;
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        L_a = '0; L_b = '0; L_c = '0;
        mode_a = '0; mode_b = 2'b11; mode_c = 2'b01;

        // Reset state
        exp_range(0, 1, 3, 4'b0000, 4'b0000, "rst_a");
        exp_range(1, 1, 3, 4'b0000, 4'b0000, "rst_b");
        exp_range(2, 1, 3, 4'b0000, 4'b0000, "rst_c");
        step(3);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        step(2);

        // ch0 rise-only: pulse 1 cycle after edge 6, level from same edge
        mode_a = 8'b00_00_00_01;
        k = cyc;
        exp_range(0, k+1, k+5, 4'b0000, 4'b0000, "a_rise_wait");
        exp_range(0, k+6, k+6, 4'b0001, 4'b0001, "a_rise_pulse");
        exp_range(0, k+7, k+9, 4'b0000, 4'b0001, "a_rise_after");
        L_a[0] = 1'b1;
        step(10);
        k = cyc;
        exp_range(0, k+1, k+5, 4'b0000, 4'b0001, "a_fall_wait");
        exp_range(0, k+6, k+8, 4'b0000, 4'b0000, "a_fall_nopulse");
        L_a[0] = 1'b0;
        step(10);

        // ch1 both-edges, 3-cycle glitch rejected
        mode_a = 8'b00_00_11_00;
        k = cyc;
        exp_range(0, k+1, k+10, 4'b0000, 4'b0000, "a_glitch");
        L_a[1] = 1'b1;
        step(3);
        L_a[1] = 1'b0;
        step(8);

        // All channels together, modes 00/01/10/11 on ch0..ch3
        mode_a = 8'b11_10_01_00;
        k = cyc;
        exp_range(0, k+1, k+5, 4'b0000, 4'b0000, "a_all_rise_wait");
        exp_range(0, k+6, k+6, 4'b1010, 4'b1111, "a_all_rise_pulse");
        exp_range(0, k+7, k+8, 4'b0000, 4'b1111, "a_all_rise_after");
        L_a = 4'b1111;
        step(10);
        k = cyc;
        exp_range(0, k+1, k+5, 4'b0000, 4'b1111, "a_all_fall_wait");
        exp_range(0, k+6, k+6, 4'b1100, 4'b0000, "a_all_fall_pulse");
        exp_range(0, k+7, k+8, 4'b0000, 4'b0000, "a_all_fall_after");
        L_a = 4'b0000;
        step(10);

        // B: latency SYNC_STAGES+1 = 4, 5-cycle pulse
        k = cyc;
        exp_range(1, k+1, k+3,  4'b0000, 4'b0000, "b_lat_wait");
        exp_range(1, k+4, k+8,  4'b0001, 4'b0001, "b_lat_pulse");
        exp_range(1, k+9, k+10, 4'b0000, 4'b0001, "b_lat_after");
        L_b = 1'b1;
        step(12);

        // B: toggles every 6 cycles -> separate 5-cycle pulses
        k = cyc;
        exp_range(1, k+1,  k+3,  4'b0000, 4'b0001, "b_t6_a");
        exp_range(1, k+4,  k+8,  4'b0001, 4'b0000, "b_t6_b");
        exp_range(1, k+9,  k+9,  4'b0000, 4'b0000, "b_t6_c");
        exp_range(1, k+10, k+14, 4'b0001, 4'b0001, "b_t6_d");
        exp_range(1, k+15, k+15, 4'b0000, 4'b0001, "b_t6_e");
        exp_range(1, k+16, k+20, 4'b0001, 4'b0000, "b_t6_f");
        exp_range(1, k+21, k+22, 4'b0000, 4'b0000, "b_t6_g");
        L_b = 1'b0;
        step(6);
        L_b = 1'b1;
        step(6);
        L_b = 1'b0;
        step(12);

        // B: toggles every 3 cycles -> reloads merge into one stretched pulse
        k = cyc;
        exp_range(1, k+1,  k+3,  4'b0000, 4'b0000, "b_t3_a");
        exp_range(1, k+4,  k+6,  4'b0001, 4'b0001, "b_t3_b");
        exp_range(1, k+7,  k+9,  4'b0001, 4'b0000, "b_t3_c");
        exp_range(1, k+10, k+14, 4'b0001, 4'b0001, "b_t3_d");
        exp_range(1, k+15, k+16, 4'b0000, 4'b0001, "b_t3_e");
        L_b = 1'b1;
        step(3);
        L_b = 1'b0;
        step(3);
        L_b = 1'b1;
        step(12);

        // C: reset mid-pulse aborts at once; L held high re-fires after release
        k = cyc;
        r = k + 9;
        exp_range(2, k+1, k+5,  4'b0000, 4'b0000, "c_wait");
        exp_range(2, k+6, k+6,  4'b0001, 4'b0001, "c_pulse");
        exp_range(2, k+7, k+9,  4'b0000, 4'b0000, "c_reset_abort");
        exp_range(2, r+1, r+5,  4'b0000, 4'b0000, "c_rel_wait");
        exp_range(2, r+6, r+9,  4'b0001, 4'b0001, "c_rel_pulse");
        exp_range(2, r+10, r+11, 4'b0000, 4'b0001, "c_rel_after");
        L_c = 1'b1;
        step(7);
        rst_c = 1'b1;
        step(2);
        rst_c = 1'b0;
        step(13);

        stim_done = 1'b1;
    end

endmodule
